wave_shaper: RTL and testbench

//   Sits directly downstream of the oscillator phase counter (count runs 1..divider).
//   On each sample_tick it converts the current phase (count/divider) into one unsigned

---
 rtl/synth_pkg.sv | 28 ++
 rtl/wave_shaper_if.sv | 43 ++++
 rtl/seq_divider.sv | 71 +++++++
 rtl/wave_shaper.sv | 140 ++++++++++++++
 tb/tb_wave_shaper.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared types and sizing helpers for the oscillator wave shaper.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package synth_pkg;

    typedef enum logic [1:0] {
        SQUARE = 2'b00,
        SAW    = 2'b01,
        TRI    = 2'b10,
        OFF    = 2'b11
    } wave_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DIV  = 2'b01,
        DONE = 2'b10
    } shaper_state_t;

    localparam int SAMPLE_W_DEF = 8;
    localparam int MAX_SAMPLE   = (1 << SAMPLE_W_DEF) - 1;

    // Numerator is count*MAX (or p*2*MAX), so it needs CNT_W+SAMPLE_W+1 bits;
    // the divider spends one clock per numerator bit.
    function automatic int div_iters(input int cnt_w, input int sample_w);
        return cnt_w + sample_w + 1;
    endfunction

endpackage

// File: rtl/wave_shaper_if.sv
// Wave shaper bus: oscillator phase in, shaped sample out.
// Latency: n/a (wiring only).
// Backpressure: none; sample_tick is a strobe and is dropped while the shaper is busy.
// Signals: en, divider, count, mode, sample_tick (to shaper);
//          sample, sample_valid, busy, overrun_count (from shaper; overrun_count only
//          when WAVE_OVERRUN_CNT_EN is defined).
interface wave_shaper_if #(
    parameter int CNT_W    = 16,
    parameter int SAMPLE_W = 8
);
    import synth_pkg::*;

    logic                en;
    logic [CNT_W-1:0]    divider;
    logic [CNT_W-1:0]    count;
    wave_mode_t          mode;
    logic                sample_tick;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                busy;
`ifdef WAVE_OVERRUN_CNT_EN
    logic [7:0]          overrun_count;

    modport master (
        output en, divider, count, mode, sample_tick,
        input  sample, sample_valid, busy, overrun_count
    );
    modport slave (
        input  en, divider, count, mode, sample_tick,
        output sample, sample_valid, busy, overrun_count
    );
`else
    modport master (
        output en, divider, count, mode, sample_tick,
        input  sample, sample_valid, busy
    );
    modport slave (
        input  en, divider, count, mode, sample_tick,
        output sample, sample_valid, busy
    );
`endif

endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// Latency: NUM_W clocks after start_i; last_o marks the final iteration cycle.
// Backpressure: none; start_i must only be raised while the divider is idle.
// Ports: clk, nrst, start_i, num_i, den_i -> last_o, quo_o, dbz_o (den == 0).
module seq_divider #(
    parameter int NUM_W = 25,
    parameter int DEN_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             last_o,
    output logic [NUM_W-1:0] quo_o,
    output logic             dbz_o
);
    localparam int ITER_W = $clog2(NUM_W + 1);

    // work_q starts as the numerator; each step shifts one numerator bit out
    // of the top and one quotient bit in at the bottom.
    logic [NUM_W-1:0]  work_q, work_d;
    logic [DEN_W-1:0]  rem_q, rem_d;
    logic [DEN_W-1:0]  den_q, den_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [DEN_W:0]    trial;

    always_comb begin
        work_d = work_q;
        rem_d  = rem_q;
        den_d  = den_q;
        iter_d = iter_q;
        trial  = {rem_q, work_q[NUM_W-1]};
        if (start_i) begin
            work_d = num_i;
            rem_d  = '0;
            den_d  = den_i;
            iter_d = ITER_W'(NUM_W);
        end else if (iter_q != '0) begin
            iter_d = iter_q - ITER_W'(1);
            // rem_q < den_q, so the trial never exceeds 2*den and the
            // difference always fits back in DEN_W bits.
            if (trial >= {1'b0, den_q}) begin
                rem_d  = DEN_W'(trial - {1'b0, den_q});
                work_d = {work_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d  = trial[DEN_W-1:0];
                work_d = {work_q[NUM_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            work_q <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            iter_q <= '0;
        end else begin
            work_q <= work_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            iter_q <= iter_d;
        end
    end

    assign last_o = (iter_q == ITER_W'(1));
    assign quo_o  = work_q;
    assign dbz_o  = (den_q == '0);

endmodule

// File: rtl/wave_shaper.sv
// Converts oscillator phase (count/divider) into a square, saw or triangle sample.
// Latency: fixed div_iters+1 clocks from the accepted sample_tick to sample_valid.
// Backpressure: none; ticks arriving while busy are dropped (counted when
// WAVE_OVERRUN_CNT_EN is defined).
// Ports: clk, nrst (async active-low), bus (wave_shaper_if.slave).
module wave_shaper
    import synth_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int SAMPLE_W = 8
) (
    input  logic          clk,
    input  logic          nrst,
    wave_shaper_if.slave  bus
);
    localparam int                  ITERS = div_iters(CNT_W, SAMPLE_W);
    localparam int                  MAX_I = (1 << SAMPLE_W) - 1;
    localparam logic [SAMPLE_W-1:0] MAX   = '1;

    shaper_state_t       state_q, state_d;
    wave_mode_t          mode_q;
    logic                en_q;
    logic                sq_hi_q;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;

    logic                start;
    logic [CNT_W-1:0]    half;
    logic [CNT_W-1:0]    tri_p;
    logic [ITERS-1:0]    num;
    logic                div_last;
    logic [ITERS-1:0]    quo;
    logic                dbz;
    logic [SAMPLE_W-1:0] sat_quo;
    logic [SAMPLE_W-1:0] result;

    assign start = (state_q == IDLE) && bus.sample_tick;

    // Operand prep straight from the live inputs; only used on the tick edge.
    always_comb begin
        half  = bus.divider >> 1;
        tri_p = (bus.count <= half) ? bus.count : (bus.divider - bus.count);
        num   = '0;
        case (bus.mode)
            SQUARE,
            SAW:     num = ITERS'(bus.count) * ITERS'(MAX_I);
            TRI:     num = ITERS'(tri_p) * ITERS'(2 * MAX_I);
            default: num = '0;
        endcase
    end

    seq_divider #(
        .NUM_W (ITERS),
        .DEN_W (CNT_W)
    ) u_div (
        .clk     (clk),
        .nrst    (nrst),
        .start_i (start),
        .num_i   (num),
        .den_i   (bus.divider),
        .last_o  (div_last),
        .quo_o   (quo),
        .dbz_o   (dbz)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = DIV;
            DIV:     if (div_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // count > divider (divider shrunk mid-period) yields quotients above MAX.
    always_comb begin
        sat_quo = (quo > ITERS'(MAX_I)) ? MAX : quo[SAMPLE_W-1:0];
        result  = '0;
        if (en_q && !dbz) begin
            case (mode_q)
                SQUARE:  result = sq_hi_q ? MAX : '0;
                SAW,
                TRI:     result = sat_quo;
                default: result = '0;
            endcase
        end
    end

    always_comb begin
        sample_d = (state_q == DONE) ? result : sample_q;
        valid_d  = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            mode_q   <= SQUARE;
            en_q     <= 1'b0;
            sq_hi_q  <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            if (start) begin
                mode_q  <= bus.mode;
                en_q    <= bus.en;
                sq_hi_q <= (bus.count > half);
            end
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = (state_q != IDLE);

`ifdef WAVE_OVERRUN_CNT_EN
    logic [7:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (bus.sample_tick && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign bus.overrun_count = ovr_q;
`endif

endmodule

// File: tb/tb_wave_shaper.sv
// Randomized self-checking bench for wave_shaper against a phase-arithmetic model.
// Latency: model expects each accepted tick to produce one sample 26 clocks later.
// Backpressure: model drops (and counts) ticks while a conversion is in flight.
module tb_wave_shaper;
    import synth_pkg::*;

    localparam int LAT = 26;

    logic clk;
    logic nrst;
    int   total;
    int   bad;
    int   cyc;

    wave_shaper_if #(.CNT_W(16), .SAMPLE_W(8)) bus ();

    wave_shaper #(.CNT_W(16), .SAMPLE_W(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT at t=%0t", nm, $time);
    endtask

    // Expected sample from the phase rules: plain integer arithmetic.
    function automatic int model_sample(input int dv, input int ct, input int md, input bit e);
        int num;
        int p;
        int q;
        if (!e || md == 3 || dv == 0) return 0;
        if (md == 0) return (ct > dv / 2) ? 255 : 0;
        if (md == 1) begin
            num = ct * 255;
        end else begin
            p   = (ct <= dv / 2) ? ct : ((dv - ct) & 32'h0000_FFFF);
            num = p * 510;
        end
        q = num / dv;
        return (q > 255) ? 255 : q;
    endfunction

    // Timeline model: remaining clocks of the in-flight conversion.
    int m_left;
    int m_pending;
    int m_sample;
    int m_ovr;
    bit m_valid;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_left    = 0;
            m_pending = 0;
            m_sample  = 0;
            m_ovr     = 0;
            m_valid   = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_left != 0) begin
                if (bus.sample_tick && m_ovr < 255) m_ovr = m_ovr + 1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_valid  = 1'b1;
                    m_sample = m_pending;
                end
            end else if (bus.sample_tick) begin
                m_pending = model_sample(int'(bus.divider), int'(bus.count),
                                         int'(bus.mode), bus.en);
                m_left    = LAT;
            end
        end
    end

    always @(negedge clk) begin
        if (nrst) begin
            check("cyc_valid",  32'(bus.sample_valid), 32'(m_valid));
            check("cyc_busy",   32'(bus.busy),         32'(m_left != 0));
            check("cyc_sample", 32'(bus.sample),       32'(m_sample));
`ifdef WAVE_OVERRUN_CNT_EN
            check("cyc_overrun", 32'(bus.overrun_count), 32'(m_ovr));
`endif
        end
    end

    task automatic set_inputs(input int dv, input int ct, input int md, input bit e);
        bus.divider = 16'(dv);
        bus.count   = 16'(ct);
        bus.mode    = wave_mode_t'(md[1:0]);
        bus.en      = e;
    endtask

    // One conversion with a literal expectation; optionally scrambles the
    // inputs mid-conversion to show the result comes from latched operands.
    task automatic run_lit(input string nm, input int dv, input int ct, input int md,
                           input bit e, input int exp, input bit scramble);
        int c0;
        int n;
        check({nm, "_model"}, 32'(model_sample(dv, ct, md, e)), 32'(exp));
        @(negedge clk);
        set_inputs(dv, ct, md, e);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        c0 = cyc;
        n  = 0;
        while (!bus.sample_valid && n < 60) begin
            @(negedge clk);
            n++;
            if (scramble && n == 5) set_inputs(7, 3, 2, 1'b0);
        end
        if (!bus.sample_valid) begin
            timeout_fail({nm, "_valid"});
        end else begin
            check({nm, "_latency"}, 32'(cyc - c0), 32'(LAT));
            check({nm, "_sample"},  32'(bus.sample), 32'(exp));
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((bus.busy || bus.sample_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail(nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int dv;
        int ct;
        int md;
        int lim;
        bit e;

        total           = 0;
        bad             = 0;
        cyc             = 0;
        nrst            = 1'b0;
        bus.sample_tick = 1'b0;
        set_inputs(0, 0, 0, 1'b0);
        #23;
        check("rst_sample", 32'(bus.sample),       32'd0);
        check("rst_valid",  32'(bus.sample_valid), 32'd0);
        check("rst_busy",   32'(bus.busy),         32'd0);
`ifdef WAVE_OVERRUN_CNT_EN
        check("rst_overrun", 32'(bus.overrun_count), 32'd0);
`endif
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        run_lit("saw_half",   100,  50, 1, 1'b1, 127, 1'b0);
        run_lit("tri_25",     100,  25, 2, 1'b1, 127, 1'b0);
        run_lit("tri_50",     100,  50, 2, 1'b1, 255, 1'b0);
        run_lit("tri_75",     100,  75, 2, 1'b1, 127, 1'b0);
        run_lit("tri_100",    100, 100, 2, 1'b1,   0, 1'b0);
        run_lit("saw_100",    100, 100, 1, 1'b1, 255, 1'b0);
        run_lit("sq_50",      100,  50, 0, 1'b1,   0, 1'b0);
        run_lit("sq_51",      100,  51, 0, 1'b1, 255, 1'b0);
        run_lit("sq_div0",      0,  51, 0, 1'b1,   0, 1'b0);
        run_lit("saw_div0",     0,  51, 1, 1'b1,   0, 1'b0);
        run_lit("tri_div0",     0,   5, 2, 1'b1,   0, 1'b0);
        run_lit("saw_en0",    100,  50, 1, 1'b0,   0, 1'b0);
        run_lit("off_mode",   100,  50, 3, 1'b1,   0, 1'b0);
        run_lit("saw_sat",    100, 130, 1, 1'b1, 255, 1'b0);
        run_lit("saw_scram",  100,  50, 1, 1'b1, 127, 1'b1);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        set_inputs(100, 75, 2, 1'b1);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_sample", 32'(bus.sample),       32'd0);
        check("arst_valid",  32'(bus.sample_valid), 32'd0);
        check("arst_busy",   32'(bus.busy),         32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        run_lit("post_rst", 100, 50, 1, 1'b1, 127, 1'b0);

        // Ticks at relative cycles 0, 5 and 20 give exactly one sample.
        wait_idle("tick_idle");
        @(negedge clk);
        set_inputs(200, 150, 1, 1'b1);
        pulses = 0;
        for (int k = 0; k < 45; k++) begin
            bus.sample_tick = (k == 0 || k == 5 || k == 20);
            @(negedge clk);
            if (bus.sample_valid) pulses++;
        end
        bus.sample_tick = 1'b0;
        check("tick_pulses", 32'(pulses), 32'd1);
        check("tick_sample", 32'(bus.sample), 32'd191);
`ifdef WAVE_OVERRUN_CNT_EN
        check("tick_overrun", 32'(bus.overrun_count), 32'd2);
`endif

        // Randomized conversions with random garbage and ticks while busy.
        for (int i = 0; i < 120; i++) begin
            wait_idle("rnd_idle");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            case ($urandom_range(0, 3))
                0:       dv = 0;
                1:       dv = $urandom_range(1, 10);
                2:       dv = $urandom_range(1, 1000);
                default: dv = $urandom_range(1, 65535);
            endcase
            md = $urandom_range(0, 3);
            e  = ($urandom_range(0, 7) != 0);
            if (md == 2 || dv == 0) begin
                ct = (dv == 0) ? $urandom_range(0, 65535) : $urandom_range(1, dv);
            end else begin
                lim = dv + dv / 4 + 1;
                if (lim > 65535) lim = 65535;
                ct = $urandom_range(1, lim);
            end
            set_inputs(dv, ct, md, e);
            bus.sample_tick = 1'b1;
            @(negedge clk);
            bus.sample_tick = 1'b0;
            while (bus.busy) begin
                set_inputs($urandom_range(0, 65535), $urandom_range(0, 65535),
                           $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                bus.sample_tick = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
            bus.sample_tick = 1'b0;
        end

        // Hold the tick high long enough to saturate the overrun counter.
        wait_idle("sat_idle");
        set_inputs(100, 50, 1, 1'b1);
        bus.sample_tick = 1'b1;
        repeat (350) @(negedge clk);
        bus.sample_tick = 1'b0;
        wait_idle("sat_end");
`ifdef WAVE_OVERRUN_CNT_EN
        check("overrun_sat", 32'(bus.overrun_count), 32'd255);
`endif
        check("sat_last_sample", 32'(bus.sample), 32'd127);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
